// File: rtl/mem_map_io_pkg.sv
// Shared register-map definitions for the memory-mapped I/O window.
package memmap;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

    typedef enum logic [2:0] {
        IoLed     = 3'd0,
        IoSw      = 3'd1,
        IoCount   = 3'd2,
        IoCompare = 3'd3,
        IoCtrl    = 3'd4,
        IoStatus  = 3'd5
    } io_reg_t;

    localparam int CTRL_TEN = 0;
    localparam int CTRL_IEN = 1;

endpackage

// File: rtl/mem_map_io_timer.sv
// Prescaled 16-bit up-counter with compare-match flag; CPU loads beat timer updates.
module io_timer #(
    parameter int PRESCALE_DIV = 16
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        enable,
    input  logic [15:0] wdata,
    input  logic        count_load,
    input  logic        compare_load,
    input  logic        status_clear,
    output logic [15:0] count,
    output logic [15:0] compare,
    output logic        flag
);

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic [15:0]   count_reg;
    logic [15:0]   compare_reg;
    logic          flag_reg;
    logic          tick;
    logic          match;

    assign tick  = enable && (presc_reg == PRESC_LAST);
    assign match = (count_reg == compare_reg);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            presc_reg   <= '0;
            count_reg   <= '0;
            compare_reg <= '0;
            flag_reg    <= 1'b0;
        end else begin
            if (enable)
                presc_reg <= tick ? '0 : presc_reg + 1'b1;

            if (count_load)
                count_reg <= wdata;
            else if (tick)
                count_reg <= match ? 16'h0000 : count_reg + 16'h0001;

            if (compare_load)
                compare_reg <= wdata;

            // A match tick setting the flag outranks a simultaneous clear
            if (tick && match)
                flag_reg <= 1'b1;
            else if (status_clear)
                flag_reg <= 1'b0;
        end
    end

    assign count   = count_reg;
    assign compare = compare_reg;
    assign flag    = flag_reg;

endmodule

// File: rtl/mem_map_io.sv
// SysBus I/O window: address latch, decode, LED/switch/timer registers and zero-latency read mux.
module mem_map_io
    import memmap::*;
#(
    parameter logic [15:0] IO_BASE      = IO_BASE_DEFAULT,
    parameter int          PRESCALE_DIV = 16
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] SysBus,
    input  logic        ALE,
    input  logic        nOE,
    input  logic        nWE,
    output logic [15:0] DataOut,
    output logic        DataOutEn,
    input  logic [15:0] Switches,
    output logic [15:0] Leds,
    output logic        Irq
);

    logic [15:0] addr_q;
    logic        nwe_q;
    logic [15:0] leds_reg;
    logic [1:0]  ctrl_reg;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic        io_sel;
    logic [2:0]  off;
    logic        wr;
    logic [15:0] rdata;
    logic [15:0] count;
    logic [15:0] compare;
    logic        flag;

    assign io_sel = (addr_q[15:3] == IO_BASE[15:3]);
    assign off    = addr_q[2:0];
    // Only the first cycle of each nWE-low period writes; nOE low too marks a non-memory cycle
    assign wr     = io_sel && !nWE && nOE && nwe_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            addr_q   <= '0;
            nwe_q    <= 1'b0;
            leds_reg <= '0;
            ctrl_reg <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            if (ALE)
                addr_q <= SysBus;
            nwe_q   <= nWE;
            sw_meta <= Switches;
            sw_sync <= sw_meta;
            if (wr && off == 3'(IoLed))
                leds_reg <= SysBus;
            if (wr && off == 3'(IoCtrl))
                ctrl_reg <= SysBus[1:0];
        end
    end

    io_timer #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_timer (
        .Clock        (Clock),
        .nReset       (nReset),
        .enable       (ctrl_reg[CTRL_TEN]),
        .wdata        (SysBus),
        .count_load   (wr && off == 3'(IoCount)),
        .compare_load (wr && off == 3'(IoCompare)),
        .status_clear (wr && off == 3'(IoStatus) && SysBus[0]),
        .count        (count),
        .compare      (compare),
        .flag         (flag)
    );

    always_comb begin
        rdata = '0;
        case (off)
            3'(IoLed):     rdata = leds_reg;
            3'(IoSw):      rdata = sw_sync;
            3'(IoCount):   rdata = count;
            3'(IoCompare): rdata = compare;
            3'(IoCtrl):    rdata = {14'h0000, ctrl_reg};
            3'(IoStatus):  rdata = {15'h0000, flag};
            default:       rdata = '0;
        endcase
    end

    assign DataOutEn = io_sel && !nOE && nWE;
    assign DataOut   = DataOutEn ? rdata : 16'h0000;
    assign Leds      = leds_reg;
    assign Irq       = flag && ctrl_reg[CTRL_IEN];

endmodule

// File: doc/mem_map_io.md
Name: mem_map_io

Overview:
- Memory-mapped I/O block on the processor SysBus, downstream of the control FSM.
- Consumes the control FSM's external-bus strobes (ALE, nOE, nWE) together with SysBus.
- Latches the access address and decodes an 8-word I/O window.
- Provides an LED register, a synchronised switch input, and a 16-bit prescaled timer with compare-match interrupt. RAM accesses outside the window are ignored.

Parameters:
- IO_BASE, 16'hFF00: I/O window base. Match on Addr[15:3] == IO_BASE[15:3].
- PRESCALE_DIV, 16: Clock cycles per timer tick. Must be ≥1.

Ports:
- Clock, input, 1: system clock, posedge.
- nReset, input, 1: asynchronous, active-low reset.
- SysBus, input, 16: address during ALE cycles; write data during write strobe.
- ALE, input, 1: address latch enable from control.
- nOE, input, 1: active-low output enable from control.
- nWE, input, 1: active-low write enable from control.
- DataOut, output, 16: read data to the SysBus pad mux.
- DataOutEn, output, 1: drive DataOut onto SysBus.
- Switches, input, 16: asynchronous board switches.
- Leds, output, 16: LED register contents.
- Irq, output, 1: timer interrupt, level.

Behaviour:
- Reset (async, nReset low): AddrQ, Leds, Count, Compare, Ctrl, Flag, prescaler, switch synchronisers and nWeQ all go to 0. Outputs DataOut=0, DataOutEn=0, Irq=0. Reset mid-access aborts it; no partial write survives.
- Address latch: at posedge Clock with ALE=1, AddrQ <= SysBus. AddrQ holds otherwise. IoSel = (AddrQ[15:3] == IO_BASE[15:3]); Off = AddrQ[2:0].
- Write strobe: Wr = IoSel & !nWE & nOE & nWeQ, where nWeQ is nWE registered at the previous edge.
  - Exactly one write per nWE-low period, on its first cycle.
  - nWE and nOE both low (non-memory cycles) is never a write.
- Register map (Off):
  - 0 LED: RW.
  - 1 SW: RO, writes ignored.
  - 2 COUNT: RW; a write loads the counter.
  - 3 COMPARE: RW.
  - 4 CTRL: RW, bits[1:0] only. Bit0 = timer enable, bit1 = interrupt enable. Reads return zero in upper bits.
  - 5 STATUS: bit0 = match Flag. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 6, 7: reserved; read 0, writes ignored.
- Read:
  - DataOutEn = IoSel & !nOE & nWE (combinational).
  - DataOut = selected register when DataOutEn=1, else 0.
  - Zero-latency, so data is valid in the control FSM's ENB cycle.
- Switches: two-flop synchroniser. SW reads return the second stage, i.e. a change appears after 2 edges.
- Timer:
  - Prescaler counts 0..PRESCALE_DIV-1 while Ctrl[0]=1; Tick=1 on the cycle it equals PRESCALE_DIV-1, then it wraps to 0.
  - Ctrl[0]=0: prescaler and Count hold their values.
  - On Tick: if Count == Compare, then Count <= 0 and Flag <= 1; otherwise Count <= Count+1 (16-bit wrap FFFF→0000).
  - Compare=0 gives a match on every tick.
- Simultaneous events:
  - CPU write to COUNT beats Tick update in the same cycle; the prescaler is unaffected.
  - Flag set and STATUS clear in the same cycle: set wins.
  - Write to CTRL clearing bit0 on a Tick cycle: the tick still applies that cycle.
- Irq = Flag & Ctrl[1], registered-source combinational output.

Decomposition:
- Package memmap: IO_BASE default, typedef enum logic[2:0] io_reg_t {IoLed, IoSw, IoCount, IoCompare, IoCtrl, IoStatus}, CTRL bit-index constants.
- Sub-module io_timer (prescaler, Count, Compare match, Flag set/clear priority). It takes load/clear strobes and write data from mem_map_io. Decode, latch and read mux stay in the top.

Test Plan:
- Reset → Leds=0000, Irq=0, DataOutEn=0. Read of LED at FF00 returns 0000.
- Write cycle: ALE with SysBus=FF00, then nWE low for 2 cycles with SysBus=A5A5 → Leds=A5A5 after first low cycle, exactly one write. Same sequence at address 1000 → Leds unchanged, DataOutEn stays 0.
- Switches=1234 asynchronously, then read FF01 after ≥2 cycles → DataOut=1234, DataOutEn=1 only while nOE=0 and nWE=1. Write to FF01 → no change.
- PRESCALE_DIV=4, COMPARE=0003, CTRL=3 → Count goes 0,1,2,3 every 4 cycles. Fourth tick → Count=0, Flag=1, Irq=1. Write STATUS=0001 → Irq=0.
- Write COUNT=0010 on a Tick cycle → Count=0010, not 0011. Flag clear on a match tick → Flag stays 1.
- Assert nReset mid-write (after ALE, nWE low) → all registers 0. No write observed after release until a new ALE.
